// File: rtl/cpu_bus.sv
`default_nettype none
// ============================================================================
// Module   : cpu_bus
// Brief    : 8-bit CPU bus bridge decoding mirrored internal RAM, unmapped
//            space and cartridge PRG with a timed, open-bus read path.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_bus #(
    parameter int RAM_ADDR_WIDTH = 11,
    parameter int PRG_TIMEOUT    = 255
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic [15:0] cpu_address_i,
    input  logic        cpu_address_valid_i,
    input  logic [7:0]  cpu_data_i,
    input  logic        cpu_data_valid_i,
    output logic [7:0]  cpu_data_o,
    output logic        cpu_data_valid_o,
    output logic [14:0] prg_address_o,
    output logic        prg_read_o,
    input  logic [7:0]  prg_data_i,
    input  logic        prg_valid_i,
    output logic        bus_error_o
);

    localparam int c_RAM_DEPTH = 1 << RAM_ADDR_WIDTH;
    localparam int c_CNT_W     = (PRG_TIMEOUT < 2) ? 1 : $clog2(PRG_TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(PRG_TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_RAM_READ = 2'd1,
        S_PRG_WAIT = 2'd2,
        S_DONE     = 2'd3
    } state_t;

    state_t                      r_state;
    logic [15:0]                 r_latched_addr;
    logic                        r_held;
    logic [7:0]                  r_data;
    logic                        r_prg_read;
    logic                        r_bus_error;
    logic [c_CNT_W-1:0]          r_wait_cnt;
    logic [7:0]                  r_ram [c_RAM_DEPTH];

    logic                        w_ready;
    logic                        w_new_req;
    logic                        w_is_ram;
    logic                        w_is_prg;
    logic                        w_ram_we;
    logic [RAM_ADDR_WIDTH-1:0]   w_ram_idx;
    logic [c_CNT_W-1:0]          w_cnt_next;

    assign w_ready   = (r_state == S_IDLE) || (r_state == S_DONE);
    // A held read of the same address is not reissued; writes always are.
    assign w_new_req = w_ready && cpu_address_valid_i &&
                       ((cpu_address_i != r_latched_addr) || !r_held || cpu_data_valid_i);
    assign w_is_ram  = (cpu_address_i[15:13] == 3'b000);
    assign w_is_prg  = cpu_address_i[15];
    assign w_ram_idx = cpu_address_i[RAM_ADDR_WIDTH-1:0];
    assign w_ram_we  = w_new_req && cpu_data_valid_i && w_is_ram && !reset_i;
    assign w_cnt_next = (r_wait_cnt == c_CNT_MAX) ? r_wait_cnt : r_wait_cnt + 1'b1;

    assign cpu_data_o       = r_data;
    assign prg_address_o    = r_latched_addr[14:0];
    assign prg_read_o       = r_prg_read;
    assign bus_error_o      = r_bus_error;
    assign cpu_data_valid_o = r_held && cpu_address_valid_i &&
                              (cpu_address_i == r_latched_addr) && !cpu_data_valid_i;

    // RAM has no reset so its contents survive a bus reset.
    always_ff @(posedge clock_i) begin
        if (w_ram_we) begin
            r_ram[w_ram_idx] <= cpu_data_i;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_state        <= S_IDLE;
            r_latched_addr <= 16'h0000;
            r_held         <= 1'b0;
            r_data         <= 8'h00;
            r_prg_read     <= 1'b0;
            r_bus_error    <= 1'b0;
            r_wait_cnt     <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_new_req) begin
                        r_latched_addr <= cpu_address_i;
                        r_held         <= 1'b0;
                        r_wait_cnt     <= '0;
                        if (cpu_data_valid_i) begin
                            r_state <= S_DONE;
                        end else if (w_is_ram) begin
                            r_state <= S_RAM_READ;
                        end else if (w_is_prg) begin
                            r_state    <= S_PRG_WAIT;
                            r_prg_read <= 1'b1;
                        end else begin
                            // Unmapped read: open bus, data register untouched.
                            r_state <= S_DONE;
                            r_held  <= 1'b1;
                        end
                    end else if (!cpu_address_valid_i) begin
                        r_held  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                S_RAM_READ: begin
                    r_data  <= r_ram[r_latched_addr[RAM_ADDR_WIDTH-1:0]];
                    r_held  <= 1'b1;
                    r_state <= S_DONE;
                end
                S_PRG_WAIT: begin
                    if (prg_valid_i) begin
                        r_data     <= prg_data_i;
                        r_held     <= 1'b1;
                        r_prg_read <= 1'b0;
                        r_state    <= S_DONE;
                    end else begin
                        r_wait_cnt <= w_cnt_next;
                        if (w_cnt_next == c_CNT_MAX) begin
                            r_bus_error <= 1'b1;
                            r_held      <= 1'b1;
                            r_prg_read  <= 1'b0;
                            r_state     <= S_DONE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu_bus.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_bus
// Brief    : Directed and randomized checks of cpu_bus against a
//            transaction-level model of RAM, PRG and open-bus behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_bus;

    localparam int c_AW      = 11;
    localparam int c_DEPTH   = 1 << c_AW;
    localparam int c_TIMEOUT = 255;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] addr;
    logic        av;
    logic [7:0]  wdata;
    logic        dv;
    logic [7:0]  data_o;
    logic        valid;
    logic [14:0] prg_addr;
    logic        prg_rd;
    logic [7:0]  pdata;
    logic        pv;
    logic        bus_err;

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0]  ram_m [c_DEPTH];
    bit          wr_m  [c_DEPTH];
    int          wr_q  [$];
    logic [7:0]  last_d;
    logic        bus_err_m;

    cpu_bus #(.RAM_ADDR_WIDTH(c_AW), .PRG_TIMEOUT(c_TIMEOUT)) dut (
        .clock_i            (clk),
        .reset_i            (rst),
        .cpu_address_i      (addr),
        .cpu_address_valid_i(av),
        .cpu_data_i         (wdata),
        .cpu_data_valid_i   (dv),
        .cpu_data_o         (data_o),
        .cpu_data_valid_o   (valid),
        .prg_address_o      (prg_addr),
        .prg_read_o         (prg_rd),
        .prg_data_i         (pdata),
        .prg_valid_i        (pv),
        .bus_error_o        (bus_err)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [15:0] a, input logic [7:0] d);
        int idx;
        addr  = a;
        wdata = d;
        av    = 1'b1;
        dv    = 1'b1;
        pv    = 1'($urandom_range(0, 1));
        pdata = 8'($urandom);
        tick;
        pv = 1'b0;
        check("wr_valid_low", valid, 0);
        av = 1'b0;
        dv = 1'b0;
        tick;
        if (a < 16'h2000) begin
            idx        = int'(a) % c_DEPTH;
            ram_m[idx] = d;
            if (!wr_m[idx]) wr_q.push_back(idx);
            wr_m[idx]  = 1'b1;
        end
    endtask

    // dly: clocks after prg_read_o rises before prg_valid_i; negative = never.
    task automatic do_read(input logic [15:0] a, input int dly, input logic [7:0] pd);
        int         n;
        int         rdc;
        int         exp_lat;
        logic [7:0] exp_d;
        if (a < 16'h2000) begin
            exp_d   = ram_m[int'(a) % c_DEPTH];
            exp_lat = 2;
        end else if (a < 16'h8000) begin
            exp_d   = last_d;
            exp_lat = 1;
        end else if (dly < 0) begin
            exp_d   = last_d;
            exp_lat = c_TIMEOUT + 1;
        end else begin
            exp_d   = pd;
            exp_lat = dly + 2;
        end
        addr = a;
        av   = 1'b1;
        dv   = 1'b0;
        check("rd_pre_valid", valid, 0);
        n   = 0;
        rdc = 0;
        while (!valid && n < 400) begin
            tick;
            n++;
            pv = 1'b0;
            if (prg_rd) begin
                if (rdc == 0) check("prg_addr", prg_addr, a[14:0]);
                if (rdc == dly) begin
                    pv    = 1'b1;
                    pdata = pd;
                end
                rdc++;
            end
        end
        pv = 1'b0;
        check("rd_latency", n, exp_lat);
        check("rd_data", data_o, exp_d);
        if (a >= 16'h8000 && dly < 0) bus_err_m = 1'b1;
        repeat (2) begin
            tick;
            check("rd_hold_valid", valid, 1);
            check("rd_no_reissue", prg_rd, 0);
        end
        check("bus_error", bus_err, bus_err_m);
        av = 1'b0;
        tick;
        check("rd_valid_drop", valid, 0);
        last_d = exp_d;
    endtask

    initial begin
        int         r;
        int         idx;
        logic [15:0] a;
        rst   = 1'b1;
        addr  = 16'h0000;
        av    = 1'b1;
        dv    = 1'b0;
        wdata = 8'h00;
        pv    = 1'b0;
        pdata = 8'h00;
        last_d    = 8'h00;
        bus_err_m = 1'b0;
        repeat (3) tick;
        check("rst_data", data_o, 8'h00);
        check("rst_valid", valid, 0);
        check("rst_prg_read", prg_rd, 0);
        check("rst_bus_error", bus_err, 0);
        av  = 1'b0;
        rst = 1'b0;
        tick;

        // Write then mirrored read.
        do_write(16'h0012, 8'h5A);
        do_read(16'h0812, 0, 8'h00);
        check("mirror_data", data_o, 8'h5A);

        // PRG read answered three clocks after the strobe.
        do_read(16'hFFFC, 3, 8'h34);

        // Open bus after a read that returned A9.
        do_read(16'h9123, 1, 8'hA9);
        do_read(16'h4000, 0, 8'h00);
        check("open_bus_data", data_o, 8'hA9);

        // Address moves to RAM while PRG transaction is in flight.
        do_write(16'h0010, 8'hC3);
        addr = 16'h8000;
        av   = 1'b1;
        tick;
        tick;
        check("chg_prg_read", prg_rd, 1);
        addr = 16'h0010;
        tick;
        check("chg_valid_0", valid, 0);
        pv    = 1'b1;
        pdata = 8'hEE;
        tick;
        pv = 1'b0;
        check("chg_valid_1", valid, 0);
        check("chg_prg_read_low", prg_rd, 0);
        tick;
        check("chg_valid_2", valid, 0);
        tick;
        check("chg_valid_3", valid, 1);
        check("chg_data", data_o, 8'hC3);
        av = 1'b0;
        tick;
        last_d = 8'hC3;

        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 4);
            case (r)
                0: do_write(16'($urandom_range(0, 16'h1FFF)), 8'($urandom));
                1: begin
                    if (wr_q.size() > 0) begin
                        idx = wr_q[$urandom_range(0, wr_q.size() - 1)];
                        a   = 16'(idx + c_DEPTH * $urandom_range(0, 3));
                        do_read(a, 0, 8'h00);
                    end
                end
                2: do_read(16'($urandom_range(16'h8000, 16'hFFFF)), $urandom_range(0, 6), 8'($urandom));
                3: do_write(16'($urandom_range(16'h2000, 16'hFFFF)), 8'($urandom));
                default: do_read(16'($urandom_range(16'h2000, 16'h7FFF)), 0, 8'h00);
            endcase
        end

        // PRG timeout: error flag, open-bus data, sticky flag.
        do_read(16'h8000, -1, 8'h00);
        do_read(16'h5555, 0, 8'h00);

        // Reset during PRG_WAIT; RAM survives.
        addr = 16'h8001;
        av   = 1'b1;
        tick;
        tick;
        check("rst_mid_prg_read_before", prg_rd, 1);
        rst = 1'b1;
        tick;
        check("rst_mid_prg_read", prg_rd, 0);
        check("rst_mid_bus_error", bus_err, 0);
        check("rst_mid_valid", valid, 0);
        rst = 1'b0;
        av  = 1'b0;
        pv    = 1'b1;
        pdata = 8'h77;
        tick;
        pv = 1'b0;
        check("rst_mid_stray_prg", data_o, 8'h00);
        last_d    = 8'h00;
        bus_err_m = 1'b0;
        do_read(16'h6000, 0, 8'h00);
        do_read(16'h0812, 0, 8'h00);
        check("rst_mid_ram_kept", data_o, 8'h5A);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
